// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: definitions shared by the audio mixer and its source watchdogs.
//   mix_state_e    - the mixing sequence, one state per AMCLK_i cycle
//   GAIN_FRAC_BITS - number of fractional bits in a gain word
//   GAIN_UNITY     - gain code that passes a sample through unchanged
package audio_mix_pkg;

  localparam int GAIN_FRAC_BITS = 7;
  localparam int GAIN_UNITY     = 128;

  // The sequence starts once per output tick. It runs one state per cycle:
  // take a snapshot, do two multiply-accumulates and a saturate for each
  // channel, then publish the result.
  typedef enum logic [3:0] {
    IDLE,
    SNAP,
    L0,
    L1,
    SATL,
    R0,
    R1,
    SATR,
    DONE
  } mix_state_e;

endpackage

// File: rtl/audio_src_watchdog.sv
// audio_src_watchdog: liveness tracker for one audio source.
//   AMCLK_i - audio master clock
//   reset   - synchronous, active-high
//   valid   - the source delivered a sample this cycle
//   tick    - an output-rate tick occurred this cycle
//   active  - registered flag: fewer than TIMEOUT_TICKS ticks since the last valid
// The counter saturates at TIMEOUT_TICKS, so a silent source stays inactive
// until its next valid. A valid wins over a tick in the same cycle.
module audio_src_watchdog #(
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic AMCLK_i,
  input  logic reset,
  input  logic valid,
  input  logic tick,
  output logic active
);

  localparam int                CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] count;

  // The active flag is registered next to the counter. src_active_o then
  // comes straight from a flop and rises the cycle after a valid.
  always_ff @(posedge AMCLK_i) begin
    if (reset) begin
      count  <= LIMIT;
      active <= 1'b0;
    end else if (valid) begin
      count  <= '0;
      active <= 1'b1;
    end else if (tick && (count != LIMIT)) begin
      count  <= count + CNT_W'(1);
      active <= (count != LIMIT - CNT_W'(1));
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// audio_mix_sched: two-source stereo mixer with per-source gain, scheduled at
// the output rate AMCLK_i / MCLK_DIVIDER.
//   AMCLK_i                      - audio master clock, the only clock
//   reset                        - synchronous, active-high
//   srcN_left_i / srcN_right_i   - signed stereo sample of source N
//   srcN_valid_i                 - one-cycle strobe qualifying source N data
//   gain0_i / gain1_i            - unsigned gains, GAIN_FRAC_BITS fractional bits
//   APDATA_LEFT_o / RIGHT_o      - saturated mix, held between results
//   APDATA_VALID_o               - one-cycle strobe, 9 cycles after each tick
//   src_active_o                 - per-source liveness from the watchdogs
// The mixing datapath has one multiplier. It is time-shared across the
// IDLE..DONE sequence, which is shorter than the divider period.
module audio_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int DATA_BITS     = 16,
  parameter int GAIN_BITS     = 8,
  parameter int MCLK_DIVIDER  = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                        AMCLK_i,
  input  logic                        reset,
  input  logic signed [DATA_BITS-1:0] src0_left_i,
  input  logic signed [DATA_BITS-1:0] src0_right_i,
  input  logic                        src0_valid_i,
  input  logic signed [DATA_BITS-1:0] src1_left_i,
  input  logic signed [DATA_BITS-1:0] src1_right_i,
  input  logic                        src1_valid_i,
  input  logic        [GAIN_BITS-1:0] gain0_i,
  input  logic        [GAIN_BITS-1:0] gain1_i,
  output logic signed [DATA_BITS-1:0] APDATA_LEFT_o,
  output logic signed [DATA_BITS-1:0] APDATA_RIGHT_o,
  output logic                        APDATA_VALID_o,
  output logic                  [1:0] src_active_o
);

  // Two gained samples plus headroom. The bound is max|s| * max(g) * 2.
  localparam int ACC_W = DATA_BITS + GAIN_BITS + 2;
  localparam int DIV_W = $clog2(MCLK_DIVIDER);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'sd1 <<< (DATA_BITS - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(64'sd1 <<< (DATA_BITS - 1)));

  // Signed sample times unsigned gain. The gain is zero-extended first so it
  // can never be read as negative.
  function automatic logic signed [ACC_W-1:0] gain_mul(
    input logic signed [DATA_BITS-1:0] sample,
    input logic        [GAIN_BITS-1:0] gain
  );
    logic signed [ACC_W-1:0] s_ext;
    logic signed [ACC_W-1:0] g_ext;
    s_ext = ACC_W'(sample);
    g_ext = ACC_W'(gain);
    return s_ext * g_ext;
  endfunction

  // Drop the gain fraction with an arithmetic shift, which rounds toward
  // -inf. Then clamp to the sample range.
  function automatic logic signed [DATA_BITS-1:0] scale_sat(
    input logic signed [ACC_W-1:0] acc_in
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = acc_in >>> GAIN_FRAC_BITS;
    if (shifted > SAT_MAX)      return DATA_BITS'(SAT_MAX);
    else if (shifted < SAT_MIN) return DATA_BITS'(SAT_MIN);
    else                        return DATA_BITS'(shifted);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic signed [DATA_BITS-1:0] hold_l0, hold_r0, hold_l1, hold_r1;
  logic signed [DATA_BITS-1:0] snap_l0, snap_r0, snap_l1, snap_r1;
  logic        [GAIN_BITS-1:0] snap_g0, snap_g1;
  logic signed [ACC_W-1:0]     acc;
  logic signed [DATA_BITS-1:0] sat_l, sat_r;
  mix_state_e                  state;

  assign tick = (div_cnt == DIV_W'(MCLK_DIVIDER - 1));

  audio_src_watchdog #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_wd0 (
    .AMCLK_i (AMCLK_i),
    .reset   (reset),
    .valid   (src0_valid_i),
    .tick    (tick),
    .active  (src_active_o[0])
  );

  audio_src_watchdog #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_wd1 (
    .AMCLK_i (AMCLK_i),
    .reset   (reset),
    .valid   (src1_valid_i),
    .tick    (tick),
    .active  (src_active_o[1])
  );

  // NOTE: every register here uses non-blocking assignment. All of them then
  // read the values from before the edge, whatever order the statements are in.
  always_ff @(posedge AMCLK_i) begin
    if (reset) begin
      // NOTE: the data registers are reset as well as the control. A
      // sequence aborted by reset then can never publish stale samples.
      div_cnt        <= '0;
      state          <= IDLE;
      hold_l0        <= '0;
      hold_r0        <= '0;
      hold_l1        <= '0;
      hold_r1        <= '0;
      snap_l0        <= '0;
      snap_r0        <= '0;
      snap_l1        <= '0;
      snap_r1        <= '0;
      snap_g0        <= '0;
      snap_g1        <= '0;
      acc            <= '0;
      sat_l          <= '0;
      sat_r          <= '0;
      APDATA_LEFT_o  <= '0;
      APDATA_RIGHT_o <= '0;
      APDATA_VALID_o <= 1'b0;
    end else begin
      // A power-of-two divider wraps by natural overflow.
      div_cnt        <= div_cnt + DIV_W'(1);
      APDATA_VALID_o <= 1'b0;

      if (src0_valid_i) begin
        hold_l0 <= src0_left_i;
        hold_r0 <= src0_right_i;
      end
      if (src1_valid_i) begin
        hold_l1 <= src1_left_i;
        hold_r1 <= src1_right_i;
      end

      case (state)
        IDLE: if (tick) state <= SNAP;
        SNAP: begin
          // The snapshot reads the hold registers' old contents. A valid
          // arriving in this cycle therefore waits for the next tick.
          snap_l0 <= hold_l0;
          snap_r0 <= hold_r0;
          snap_l1 <= hold_l1;
          snap_r1 <= hold_r1;
          snap_g0 <= src_active_o[0] ? gain0_i : '0;
          snap_g1 <= src_active_o[1] ? gain1_i : '0;
          state   <= L0;
        end
        L0: begin
          acc   <= gain_mul(snap_l0, snap_g0);
          state <= L1;
        end
        L1: begin
          acc   <= acc + gain_mul(snap_l1, snap_g1);
          state <= SATL;
        end
        SATL: begin
          sat_l <= scale_sat(acc);
          state <= R0;
        end
        R0: begin
          acc   <= gain_mul(snap_r0, snap_g0);
          state <= R1;
        end
        R1: begin
          acc   <= acc + gain_mul(snap_r1, snap_g1);
          state <= SATR;
        end
        SATR: begin
          sat_r <= scale_sat(acc);
          state <= DONE;
        end
        DONE: begin
          APDATA_LEFT_o  <= sat_l;
          APDATA_RIGHT_o <= sat_r;
          APDATA_VALID_o <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_mix_sched.md
AUDIO_MIX_SCHED -- requirements
Module: audio_mix_sched

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16: signed sample width on all sample ports.
REQ-002 SHALL have parameter GAIN_BITS, default 8: unsigned gain width, 7 fractional bits, so 128 = unity.
REQ-003 SHALL have parameter MCLK_DIVIDER, default 16: output rate is AMCLK_i/MCLK_DIVIDER; must be a power of 2 and >= 16.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 4096: number of output ticks without a valid before a source is declared inactive.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- AMCLK_i  in  1  audio master clock, the only clock.
- reset  in  1  synchronous, active-high.
- src0_left_i, src0_right_i  in  DATA_BITS  source 0 stereo sample, signed.
- src0_valid_i  in  1  single-cycle strobe that qualifies src0 data.
- src1_left_i, src1_right_i, src1_valid_i: as src0, for source 1.
- gain0_i, gain1_i  in  GAIN_BITS  per-source gain.
- APDATA_LEFT_o, APDATA_RIGHT_o  out  DATA_BITS  mixed output, signed.
- APDATA_VALID_o  out  1  one-cycle output strobe.
- src_active_o  out  2  bit n is high while source n is active.

Function
REQ-006 SHALL capture srcN L/R into the hold registers in every cycle in which srcN_valid_i=1.
REQ-007 SHALL run a free-running divider 0..MCLK_DIVIDER-1, starting at 0 after reset; tick = (divider == MCLK_DIVIDER-1).
REQ-008 SHALL use FSM states IDLE, SNAP, L0, L1, SATL, R0, R1, SATR, DONE, advancing one state per cycle; IDLE->SNAP only on tick; DONE->IDLE unconditionally.
REQ-009 SHALL in SNAP copy both hold registers, gains and active flags into snapshot registers; a valid arriving in the SNAP cycle updates hold only and is used at the next tick.
REQ-010 SHALL use effective gain geffN = gainN if sourceN is active, else 0.
REQ-011 SHALL compute in L0: acc = s0L*geff0; in L1: acc += s1L*geff1; R0/R1: the same for the right channel; gain zero-extended to signed; acc width DATA_BITS+GAIN_BITS+2 (26 bits).
REQ-012 SHALL in SATL/SATR form acc >>> 7 (arithmetic shift, floor), then saturate to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
REQ-013 SHALL in DONE register APDATA_LEFT_o/RIGHT_o and pulse APDATA_VALID_o; outputs are visible and VALID=1 exactly 9 cycles after the tick cycle, for 1 cycle, with data held until the next DONE.
REQ-014 SHALL keep one watchdog per source: tick counter cleared on valid, incremented on tick, saturating at TIMEOUT_TICKS; active = counter < TIMEOUT_TICKS.
REQ-015 SHALL give priority to valid when valid and tick occur in the same cycle (counter cleared).
REQ-016 SHALL drive src_active_o directly from the watchdog registers; an active source becomes active 1 cycle after a valid.

Reset
REQ-017 SHALL on reset set APDATA_*_o=0, APDATA_VALID_o=0, FSM=IDLE, divider=0, hold/snapshot/acc=0, watchdog counters=TIMEOUT_TICKS (src_active_o=00).
REQ-018 SHALL abort an in-progress sequence when reset occurs mid-sequence, with no VALID pulse for the aborted tick.

Structure
REQ-019 SHALL place the FSM state enum, GAIN_FRAC_BITS=7 and GAIN_UNITY=128 in package audio_mix_pkg.
REQ-020 SHALL implement the watchdog as sub-module audio_src_watchdog, instantiated twice.

Verification
REQ-021 SHALL cover: reset, no valids -> VALID every 16 cycles, outputs 0, src_active_o=00.
REQ-022 SHALL cover: src0 valid L=0x1000, R=0xF000, gain0=128, src1 idle -> next outputs L=0x1000, R=0xF000.
REQ-023 SHALL cover: both sources L=30000, gains 128 -> L=32767; both L=-30000 -> L=-32768.
REQ-024 SHALL cover: src0 L=1001, gain0=64 -> 500; L=-1001 -> -501.
REQ-025 SHALL cover: src0 silent for 4096 ticks -> src_active_o[0]=0 and contribution 0; one valid -> active again the next cycle.
REQ-026 SHALL cover: reset asserted 4 cycles after a tick -> no VALID for that tick, outputs 0.
